// File: rtl/bmd_rc_pkg.sv
// Shared constants for the BMD requester-completion receive path:
// FSM encoding, SOP descriptor field offsets and completion status codes.
package bmd_rc_pkg;

    localparam int TAG_NUM = 256;
    localparam int TAG_W   = 8;
    localparam int REM_W   = 13;

    typedef logic [1:0] rc_state_t;
    localparam rc_state_t ST_IDLE = 2'd0;
    localparam rc_state_t ST_DATA = 2'd1;
    localparam rc_state_t ST_DROP = 2'd2;

    // Bit offsets inside the first (descriptor) beat of a completion
    localparam int DESC_BC_LSB     = 16;
    localparam int DESC_RC_BIT     = 30;
    localparam int DESC_DW_LSB     = 32;
    localparam int DESC_ST_LSB     = 43;
    localparam int DESC_POISON_BIT = 46;
    localparam int DESC_TAG_LSB    = 64;
    localparam int DESC_DWORDS     = 3;

    typedef enum logic [2:0] {
        CPL_SC  = 3'b000,
        CPL_UR  = 3'b001,
        CPL_CRS = 3'b010,
        CPL_CA  = 3'b100
    } cpl_status_e;

    function automatic logic [REM_W-1:0] dw_to_bytes(input logic [10:0] dw);
        return {dw, 2'b00};
    endfunction

endpackage

// File: rtl/bmd_rc_tag_table.sv
// Outstanding-read table: one valid bit and a 13-bit remaining byte count per tag,
// with a set port for new requests and an update/retire port for completions.
module bmd_rc_tag_table #(
    parameter int NUM_TAGS = 256
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_set_en,
    input  logic [bmd_rc_pkg::TAG_W-1:0]  i_set_tag,
    input  logic [bmd_rc_pkg::REM_W-1:0]  i_set_bytes,
    input  logic                          i_upd_en,
    input  logic                          i_ret_en,
    input  logic [bmd_rc_pkg::TAG_W-1:0]  i_upd_tag,
    input  logic [bmd_rc_pkg::REM_W-1:0]  i_upd_rem,
    input  logic [bmd_rc_pkg::TAG_W-1:0]  i_rd_tag,
    output logic                          o_rd_valid,
    output logic [bmd_rc_pkg::REM_W-1:0]  o_rd_rem,
    input  logic [bmd_rc_pkg::TAG_W-1:0]  i_chk_tag,
    output logic                          o_chk_free
);
    import bmd_rc_pkg::*;

    logic [NUM_TAGS-1:0] r_valid;
    logic [REM_W-1:0]    r_rem [NUM_TAGS];

    // A retire for the same tag as a set is ordered last so it wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else begin
            if (i_set_en) r_valid[i_set_tag] <= 1'b1;
            if (i_ret_en) r_valid[i_upd_tag] <= 1'b0;
        end
    end

    // Remaining counts are only meaningful while the valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_set_en) r_rem[i_set_tag] <= i_set_bytes;
        if (i_upd_en) r_rem[i_upd_tag] <= i_upd_rem;
    end

    assign o_rd_valid = r_valid[i_rd_tag];
    assign o_rd_rem   = r_rem[i_rd_tag];
    assign o_chk_free = ~r_valid[i_chk_tag];

endmodule

// File: rtl/bmd_rc_cpl_rx.sv
// Requester-completion receiver: matches RC completions to outstanding read tags,
// checks payload against a fixed pattern and keeps completion/byte counters.
module bmd_rc_cpl_rx #(
    parameter int C_DATA_WIDTH        = 512,
    parameter int AXI4_RC_TUSER_WIDTH = 161,
    parameter int TAG_NUM             = bmd_rc_pkg::TAG_NUM
)(
    input  logic                           user_clk,
    input  logic                           sys_rst,
    input  logic                           user_lnk_up,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_rc_tdata,
    input  logic [C_DATA_WIDTH/32-1:0]     m_axis_rc_tkeep,
    input  logic                           m_axis_rc_tlast,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
    input  logic                           m_axis_rc_tvalid,
    output logic                           m_axis_rc_tready,
    input  logic                           req_valid,
    input  logic [7:0]                     req_tag,
    input  logic [12:0]                    req_bytes,
    output logic                           req_ready,
    input  logic [31:0]                    cfg_pattern,
    input  logic                           clear,
    output logic [31:0]                    cpl_done_cnt,
    output logic [31:0]                    cpl_byte_cnt,
    output logic [8:0]                     outstanding,
    output logic                           err_unexp_tag,
    output logic                           err_status,
    output logic                           err_pattern,
    output logic                           err_len
);
    import bmd_rc_pkg::*;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             r_tready;
    rc_state_t        r_state;
    rc_state_t        w_state_nxt;
    logic [TAG_W-1:0] r_tag;
    logic             r_req_cpl;
    logic             r_good;
    logic [REM_W-1:0] r_rem;
    logic [31:0]      r_done_cnt;
    logic [31:0]      r_byte_cnt;
    logic [8:0]       r_outstanding;
    logic             r_err_unexp, r_err_status, r_err_pattern, r_err_len;

    logic             w_acc, w_sop, w_in_idle;
    logic [TAG_W-1:0] w_d_tag;
    logic             w_d_rc, w_d_poison;
    logic [10:0]      w_d_dw;
    logic [2:0]       w_d_status;
    logic [REM_W-1:0] w_bytes;
    logic             w_rd_valid;
    logic [REM_W-1:0] w_rd_rem;
    logic [REM_W:0]   w_sub;
    logic             w_uflow;
    logic             w_unexp, w_stat, w_good_sop;
    logic             w_end, w_end_rc, w_done, w_len_err, w_ret, w_set;
    logic [REM_W-1:0] w_end_rem;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_chk_en, w_pat_bad, w_chk_free;
    logic             w_unused;

    // Reset asserts asynchronously, releases on a user_clk edge.
    always_ff @(posedge user_clk or negedge sys_rst) begin
        if (!sys_rst) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_acc      = m_axis_rc_tvalid & r_tready & user_lnk_up;
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_sop      = w_acc & w_in_idle;
    assign w_d_tag    = m_axis_rc_tdata[DESC_TAG_LSB +: TAG_W];
    assign w_d_rc     = m_axis_rc_tdata[DESC_RC_BIT];
    assign w_d_dw     = m_axis_rc_tdata[DESC_DW_LSB +: 11];
    assign w_d_status = m_axis_rc_tdata[DESC_ST_LSB +: 3];
    assign w_d_poison = m_axis_rc_tdata[DESC_POISON_BIT];
    assign w_bytes    = dw_to_bytes(w_d_dw);

    assign w_sub      = {1'b0, w_rd_rem} - {1'b0, w_bytes};
    assign w_uflow    = w_sub[REM_W];
    assign w_unexp    = w_sop & ~w_rd_valid;
    assign w_stat     = w_sop & w_rd_valid & ((w_d_status != CPL_SC) | w_d_poison);
    assign w_good_sop = w_sop & w_rd_valid & ~((w_d_status != CPL_SC) | w_d_poison);

    assign w_end_rc   = w_in_idle ? w_d_rc : r_req_cpl;
    assign w_end_rem  = w_in_idle ? w_sub[REM_W-1:0] : r_rem;
    assign w_upd_tag  = w_in_idle ? w_d_tag : r_tag;
    assign w_end      = m_axis_rc_tlast & ((w_good_sop & ~w_uflow) |
                                           (w_acc & (r_state == ST_DATA) & r_good));
    assign w_done     = w_end & w_end_rc & (w_end_rem == '0);
    assign w_len_err  = (w_good_sop & w_uflow) | (w_end & w_end_rc & (w_end_rem != '0));
    assign w_ret      = w_stat | (w_good_sop & w_uflow) | (w_end & w_end_rc);
    assign w_set      = req_valid & w_chk_free & user_lnk_up;

    assign w_chk_en = w_good_sop | (w_acc & (r_state == ST_DATA));
    always_comb begin
        w_pat_bad = 1'b0;
        for (int i = 0; i < C_DATA_WIDTH/32; i++) begin
            if (w_chk_en && m_axis_rc_tkeep[i] && (i >= DESC_DWORDS || !w_in_idle) &&
                m_axis_rc_tdata[32*i +: 32] != cfg_pattern)
                w_pat_bad = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!user_lnk_up)
            w_state_nxt = ST_IDLE;
        else if (w_acc) begin
            if (m_axis_rc_tlast)
                w_state_nxt = ST_IDLE;
            else if (w_in_idle)
                w_state_nxt = (w_unexp || w_stat) ? ST_DROP : ST_DATA;
        end
    end

    bmd_rc_tag_table #(.NUM_TAGS(TAG_NUM)) u_tag_table (
        .i_clk       (user_clk),
        .i_rst_n     (w_rst_n),
        .i_flush     (~user_lnk_up),
        .i_set_en    (w_set),
        .i_set_tag   (req_tag),
        .i_set_bytes (req_bytes),
        .i_upd_en    (w_good_sop),
        .i_ret_en    (w_ret),
        .i_upd_tag   (w_upd_tag),
        .i_upd_rem   (w_sub[REM_W-1:0]),
        .i_rd_tag    (w_d_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_rem    (w_rd_rem),
        .i_chk_tag   (req_tag),
        .o_chk_free  (w_chk_free)
    );

    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tready      <= 1'b0;
            r_state       <= ST_IDLE;
            r_tag         <= '0;
            r_req_cpl     <= 1'b0;
            r_good        <= 1'b0;
            r_rem         <= '0;
            r_outstanding <= '0;
        end else begin
            r_tready <= user_lnk_up;
            r_state  <= w_state_nxt;
            if (w_sop) begin
                r_tag     <= w_d_tag;
                r_req_cpl <= w_d_rc;
                r_good    <= w_good_sop & ~w_uflow;
                r_rem     <= w_sub[REM_W-1:0];
            end
            if (!user_lnk_up)
                r_outstanding <= '0;
            else
                r_outstanding <= r_outstanding + {8'd0, w_set} - {8'd0, w_ret};
        end
    end

    // Clear has priority: an event in the clear cycle is dropped.
    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_done_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_err_unexp   <= 1'b0;
            r_err_status  <= 1'b0;
            r_err_pattern <= 1'b0;
            r_err_len     <= 1'b0;
        end else if (clear) begin
            r_done_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_err_unexp   <= 1'b0;
            r_err_status  <= 1'b0;
            r_err_pattern <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            if (w_done)     r_done_cnt    <= r_done_cnt + 32'd1;
            if (w_good_sop) r_byte_cnt    <= r_byte_cnt + {19'd0, w_bytes};
            if (w_unexp)    r_err_unexp   <= 1'b1;
            if (w_stat)     r_err_status  <= 1'b1;
            if (w_pat_bad)  r_err_pattern <= 1'b1;
            if (w_len_err)  r_err_len     <= 1'b1;
        end
    end

    assign m_axis_rc_tready = r_tready;
    assign req_ready        = w_chk_free;
    assign cpl_done_cnt     = r_done_cnt;
    assign cpl_byte_cnt     = r_byte_cnt;
    assign outstanding      = r_outstanding;
    assign err_unexp_tag    = r_err_unexp;
    assign err_status       = r_err_status;
    assign err_pattern      = r_err_pattern;
    assign err_len          = r_err_len;

    assign w_unused = ^{m_axis_rc_tuser, m_axis_rc_tdata[DESC_BC_LSB +: REM_W]};

endmodule

// File: tb/tb_bmd_rc_cpl_rx.sv
// Bench for bmd_rc_cpl_rx: directed scenarios then random traffic, all checked
// against a packet-level model of the tag table, counters and error flags.
module tb_bmd_rc_cpl_rx;
    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic          user_clk = 1'b0;
    logic          sys_rst;
    logic          user_lnk_up;
    logic [511:0]  m_axis_rc_tdata;
    logic [15:0]   m_axis_rc_tkeep;
    logic          m_axis_rc_tlast;
    logic [160:0]  m_axis_rc_tuser;
    logic          m_axis_rc_tvalid;
    logic          m_axis_rc_tready;
    logic          req_valid;
    logic [7:0]    req_tag;
    logic [12:0]   req_bytes;
    logic          req_ready;
    logic [31:0]   cfg_pattern;
    logic          clear;
    logic [31:0]   cpl_done_cnt;
    logic [31:0]   cpl_byte_cnt;
    logic [8:0]    outstanding;
    logic          err_unexp_tag, err_status, err_pattern, err_len;

    always #5 user_clk = ~user_clk;

    bmd_rc_cpl_rx dut (
        .user_clk         (user_clk),
        .sys_rst          (sys_rst),
        .user_lnk_up      (user_lnk_up),
        .m_axis_rc_tdata  (m_axis_rc_tdata),
        .m_axis_rc_tkeep  (m_axis_rc_tkeep),
        .m_axis_rc_tlast  (m_axis_rc_tlast),
        .m_axis_rc_tuser  (m_axis_rc_tuser),
        .m_axis_rc_tvalid (m_axis_rc_tvalid),
        .m_axis_rc_tready (m_axis_rc_tready),
        .req_valid        (req_valid),
        .req_tag          (req_tag),
        .req_bytes        (req_bytes),
        .req_ready        (req_ready),
        .cfg_pattern      (cfg_pattern),
        .clear            (clear),
        .cpl_done_cnt     (cpl_done_cnt),
        .cpl_byte_cnt     (cpl_byte_cnt),
        .outstanding      (outstanding),
        .err_unexp_tag    (err_unexp_tag),
        .err_status       (err_status),
        .err_pattern      (err_pattern),
        .err_len          (err_len)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    bit          m_valid [256];
    int unsigned m_rem   [256];
    logic [31:0] m_done, m_bytes;
    int          m_out;
    bit          m_unexp, m_stat, m_pat, m_len;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk_eq({tag, ".done"},  cpl_done_cnt, m_done);
        chk_eq({tag, ".bytes"}, cpl_byte_cnt, m_bytes);
        chk_eq({tag, ".out"},   32'(outstanding), 32'(m_out));
        chk_eq({tag, ".unexp"}, 32'(err_unexp_tag), 32'(m_unexp));
        chk_eq({tag, ".stat"},  32'(err_status), 32'(m_stat));
        chk_eq({tag, ".pat"},   32'(err_pattern), 32'(m_pat));
        chk_eq({tag, ".len"},   32'(err_len), 32'(m_len));
    endtask

    task automatic do_req(input logic [7:0] tag, input int bytes);
        bit exp_rr;
        exp_rr    = !m_valid[tag];
        req_valid = 1'b1;
        req_tag   = tag;
        req_bytes = 13'(bytes);
        #1;
        chk_eq("req.ready", 32'(req_ready), 32'(exp_rr));
        tick();
        req_valid = 1'b0;
        if (exp_rr) begin
            m_valid[tag] = 1'b1;
            m_rem[tag]   = bytes;
            m_out++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        m_done  = '0;
        m_bytes = '0;
        m_unexp = 0; m_stat = 0; m_pat = 0; m_len = 0;
    endtask

    // Drives one completion; an optional request rides on the last beat and
    // abort_at>0 stops after that many beats (model left to the caller).
    task automatic send_cpl(input logic [7:0] tag, input int dw, input bit rc,
                            input logic [2:0] st, input bit poi, input int bad_idx,
                            input bit with_req, input logic [7:0] rtag, input int rbytes,
                            input int abort_at, output bit aborted);
        logic [511:0] data;
        logic [15:0]  keep;
        int           p, nb, s0;
        bit           last, exp_rr, do_set, good;
        p = 0; nb = 0; aborted = 0; last = 0;
        exp_rr = !m_valid[rtag];
        do_set = with_req && exp_rr;
        while (!last) begin
            if (abort_at != 0 && nb == abort_at) begin
                aborted = 1;
                break;
            end
            for (int s = 0; s < 16; s++) data[32*s +: 32] = $urandom;
            keep = '0;
            s0   = 0;
            if (nb == 0) begin
                data[31:0]  = {1'b0, rc, 1'b0, 13'(4*dw), 16'h0};
                data[63:32] = {17'h0, poi, st, 11'(dw)};
                data[95:64] = {24'h0, tag};
                keep[2:0]   = 3'b111;
                s0          = 3;
            end
            for (int s = s0; s < 16; s++) begin
                if (p < dw) begin
                    data[32*s +: 32] = (p == bad_idx) ? 32'hDEADBEEF : PAT;
                    keep[s] = 1'b1;
                    p++;
                end
            end
            last = (p >= dw);
            m_axis_rc_tdata  = data;
            m_axis_rc_tkeep  = keep;
            m_axis_rc_tlast  = last;
            m_axis_rc_tvalid = 1'b1;
            if (last && with_req) begin
                req_valid = 1'b1;
                req_tag   = rtag;
                req_bytes = 13'(rbytes);
                #1;
                chk_eq("coll.req_ready", 32'(req_ready), 32'(exp_rr));
            end
            tick();
            nb++;
        end
        m_axis_rc_tvalid = 1'b0;
        m_axis_rc_tlast  = 1'b0;
        req_valid        = 1'b0;
        if (!aborted) begin
            good = 0;
            if (!m_valid[tag]) begin
                m_unexp = 1;
            end else if (st != 3'b000 || poi) begin
                m_stat = 1; m_valid[tag] = 0; m_out--;
            end else begin
                good    = 1;
                m_bytes = m_bytes + 32'(4*dw);
                if (4*dw > m_rem[tag]) begin
                    m_len = 1; m_valid[tag] = 0; m_out--;
                end else begin
                    m_rem[tag] = m_rem[tag] - 4*dw;
                    if (rc) begin
                        m_valid[tag] = 0; m_out--;
                        if (m_rem[tag] == 0) m_done = m_done + 1;
                        else                 m_len  = 1;
                    end
                end
            end
            if (good && bad_idx >= 0 && bad_idx < dw) m_pat = 1;
            if (do_set) begin
                m_valid[rtag] = 1; m_rem[rtag] = rbytes; m_out++;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ab;
        int          kind, dw, bad, q, prev_out;
        bit          rc, poi;
        logic [2:0]  st;
        logic [7:0]  t;

        sys_rst = 0; user_lnk_up = 0; clear = 0; cfg_pattern = PAT;
        m_axis_rc_tdata = '0; m_axis_rc_tkeep = '0; m_axis_rc_tlast = 0;
        m_axis_rc_tuser = '0; m_axis_rc_tvalid = 0;
        req_valid = 0; req_tag = '0; req_bytes = '0;
        for (int i = 0; i < 256; i++) begin m_valid[i] = 0; m_rem[i] = 0; end
        m_done = '0; m_bytes = '0; m_out = 0;
        m_unexp = 0; m_stat = 0; m_pat = 0; m_len = 0;

        repeat (3) @(posedge user_clk);
        #1;
        chk_eq("rst.tready", 32'(m_axis_rc_tready), 32'd0);
        chk_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_all("rst");
        sys_rst = 1;
        repeat (4) tick();
        chk_eq("lnkdn.tready", 32'(m_axis_rc_tready), 32'd0);
        user_lnk_up = 1;
        tick();
        chk_eq("lnkup.tready", 32'(m_axis_rc_tready), 32'd1);

        // Single full completion
        do_req(8'd5, 512);
        chk_eq("t25.out_pre", 32'(outstanding), 32'd1);
        send_cpl(8'd5, 128, 1, 3'b000, 0, -1, 0, 8'd0, 0, 0, ab);
        chk_eq("t25.done", cpl_done_cnt, 32'd1);
        chk_eq("t25.bytes", cpl_byte_cnt, 32'd512);
        check_all("t25");

        // Split completion: done only after the second
        do_req(8'd9, 1024);
        send_cpl(8'd9, 128, 0, 3'b000, 0, -1, 0, 8'd0, 0, 0, ab);
        chk_eq("t26.done_mid", cpl_done_cnt, 32'd1);
        send_cpl(8'd9, 128, 1, 3'b000, 0, -1, 0, 8'd0, 0, 0, ab);
        chk_eq("t26.done_end", cpl_done_cnt, 32'd2);
        check_all("t26");

        // Unexpected tag
        send_cpl(8'h22, 20, 1, 3'b000, 0, -1, 0, 8'd0, 0, 0, ab);
        chk_eq("t27.unexp", 32'(err_unexp_tag), 32'd1);
        chk_eq("t27.bytes", cpl_byte_cnt, 32'd1536);
        check_all("t27");

        // Pattern error and clear
        do_req(8'd3, 64);
        send_cpl(8'd3, 16, 1, 3'b000, 0, 5, 0, 8'd0, 0, 0, ab);
        chk_eq("t28.pat", 32'(err_pattern), 32'd1);
        do_clear();
        chk_eq("t28.pat_clr", 32'(err_pattern), 32'd0);
        check_all("t28");

        // Error status frees the tag
        do_req(8'd7, 256);
        send_cpl(8'd7, 10, 1, 3'b001, 0, -1, 0, 8'd0, 0, 0, ab);
        chk_eq("t29.stat", 32'(err_status), 32'd1);
        req_tag = 8'd7;
        #1;
        chk_eq("t29.req_ready7", 32'(req_ready), 32'd1);
        check_all("t29");

        // Retire vs request on the same tag, then on different tags
        do_req(8'd10, 40);
        send_cpl(8'd10, 10, 1, 3'b000, 0, -1, 1, 8'd10, 64, 0, ab);
        check_all("t16");
        do_req(8'd11, 40);
        prev_out = m_out;
        send_cpl(8'd11, 10, 1, 3'b000, 0, -1, 1, 8'd12, 64, 0, ab);
        chk_eq("t17.out_same", 32'(outstanding), 32'(prev_out));
        check_all("t17");

        // Link drop mid-packet
        do_req(8'd20, 512);
        do_req(8'd21, 512);
        do_req(8'd22, 512);
        send_cpl(8'd20, 128, 1, 3'b000, 0, -1, 0, 8'd0, 0, 2, ab);
        m_bytes = m_bytes + 32'd512;
        user_lnk_up = 0;
        tick();
        for (int i = 0; i < 256; i++) m_valid[i] = 0;
        m_out = 0;
        chk_eq("t30.out", 32'(outstanding), 32'd0);
        chk_eq("t30.tready", 32'(m_axis_rc_tready), 32'd0);
        req_tag = 8'd21;
        #1;
        chk_eq("t30.req_ready21", 32'(req_ready), 32'd1);
        check_all("t30");
        user_lnk_up = 1;
        tick();
        tick();
        do_req(8'd5, 64);
        send_cpl(8'd5, 16, 1, 3'b000, 0, -1, 0, 8'd0, 0, 0, ab);
        check_all("t30b");

        // Random traffic on a small tag pool
        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 9);
            t    = 8'($urandom_range(0, 15));
            if (kind <= 2) begin
                do_req(t, 4 * $urandom_range(1, 256));
            end else if (kind <= 7) begin
                st  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                poi = ($urandom_range(0, 15) == 0);
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : -1;
                if ($urandom_range(0, 15) == 0) t = 8'h40 + 8'($urandom_range(0, 15));
                if (m_valid[t]) begin
                    q = m_rem[t] / 4;
                    case ($urandom_range(0, 5))
                        0, 1, 2: begin dw = (q == 0) ? 1 : q; rc = 1; end
                        3:       begin dw = $urandom_range(1, (q == 0) ? 1 : q); rc = 0; end
                        4:       begin dw = $urandom_range(1, (q == 0) ? 1 : q); rc = 1; end
                        default: begin dw = q + 1; rc = ($urandom_range(0, 1) == 1); end
                    endcase
                end else begin
                    dw = $urandom_range(1, 40);
                    rc = 1;
                end
                send_cpl(t, dw, rc, st, poi, bad, 0, 8'd0, 0, 0, ab);
            end else begin
                do_clear();
            end
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
